// File: rtl/fir_pkg.sv
// Shared constants and types for the unfolded FIR datapath: sample width,
// lane count and the packer slot-state encoding.
package fir_pkg;

  localparam int unsigned NB_DEFAULT = 8;
  // Unfolding factor shared with myfir and data_sink
  localparam int unsigned NLANES     = 3;

  typedef enum logic [1:0] {
    S0,
    S1,
    S2
  } slot_state_e;

endpackage

// File: rtl/fir_sp_packer.sv
// Serial-to-parallel packer: groups three valid samples into one block for myfir,
// with zero-padded flush. Define PACKER_CNT_EN to add the BLK_CNT block counter.
module fir_sp_packer
  import fir_pkg::*;
#(
  parameter int unsigned NB = NB_DEFAULT
`ifdef PACKER_CNT_EN
  ,
  parameter int unsigned CNTW = 16
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          VIN,
  input  logic [NB-1:0] DIN,
  input  logic          FLUSH,
  output logic [NB-1:0] DOUT_0,
  output logic [NB-1:0] DOUT_1,
  output logic [NB-1:0] DOUT_2,
  output logic          VOUT,
`ifdef PACKER_CNT_EN
  output logic [CNTW-1:0] BLK_CNT,
`endif
  output logic          BUSY
);

  // Only the first NLANES-1 samples need holding; the last one goes straight out.
  logic [NB-1:0] r_slot [NLANES-1];
  slot_state_e   r_state;
  logic [NB-1:0] r_dout_0;
  logic [NB-1:0] r_dout_1;
  logic [NB-1:0] r_dout_2;
  logic          r_vout;
  logic          r_busy;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S0;
      r_slot   <= '{default: '0};
      r_dout_0 <= '0;
      r_dout_1 <= '0;
      r_dout_2 <= '0;
      r_vout   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_vout <= 1'b0;
      unique case (r_state)
        S0: begin
          if (VIN) begin
            r_slot[0] <= DIN;
            if (FLUSH) begin
              // Sample lands in slot 0, then the flush emits it alone.
              r_dout_0 <= DIN;
              r_dout_1 <= '0;
              r_dout_2 <= '0;
              r_vout   <= 1'b1;
              r_state  <= S0;
              r_busy   <= 1'b0;
            end else begin
              r_state <= S1;
              r_busy  <= 1'b1;
            end
          end
        end
        S1: begin
          if (VIN) begin
            r_slot[1] <= DIN;
            if (FLUSH) begin
              r_dout_0 <= r_slot[0];
              r_dout_1 <= DIN;
              r_dout_2 <= '0;
              r_vout   <= 1'b1;
              r_state  <= S0;
              r_busy   <= 1'b0;
            end else begin
              r_state <= S2;
              r_busy  <= 1'b1;
            end
          end else if (FLUSH) begin
            r_dout_0 <= r_slot[0];
            r_dout_1 <= '0;
            r_dout_2 <= '0;
            r_vout   <= 1'b1;
            r_state  <= S0;
            r_busy   <= 1'b0;
          end
        end
        S2: begin
          // A completed block already empties the packer, so FLUSH adds nothing.
          if (VIN) begin
            r_dout_0 <= r_slot[0];
            r_dout_1 <= r_slot[1];
            r_dout_2 <= DIN;
            r_vout   <= 1'b1;
            r_state  <= S0;
            r_busy   <= 1'b0;
          end else if (FLUSH) begin
            r_dout_0 <= r_slot[0];
            r_dout_1 <= r_slot[1];
            r_dout_2 <= '0;
            r_vout   <= 1'b1;
            r_state  <= S0;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state <= S0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PACKER_CNT_EN
  logic [CNTW-1:0] r_blk_cnt;
  logic            w_emit;

  // Mirrors every condition above that sets r_vout.
  always_comb begin
    w_emit = 1'b0;
    unique case (r_state)
      S0:      w_emit = VIN && FLUSH;
      S1:      w_emit = FLUSH;
      S2:      w_emit = VIN || FLUSH;
      default: w_emit = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blk_cnt <= '0;
    end else if (w_emit) begin
      r_blk_cnt <= r_blk_cnt + 1'b1;
    end
  end

  assign BLK_CNT = r_blk_cnt;
`endif

  assign DOUT_0 = r_dout_0;
  assign DOUT_1 = r_dout_1;
  assign DOUT_2 = r_dout_2;
  assign VOUT   = r_vout;
  assign BUSY   = r_busy;

endmodule
